// File: rtl/prco_fetch_pkg.sv
// Shared constants and FSM state encoding for the PRCO instruction fetch stage.
package prco_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH_ISSUE = 2'd0,
        FETCH_WAIT  = 2'd1,
        FETCH_HOLD  = 2'd2
    } fetch_state_t;

    localparam logic [15:0] RESET_VECTOR = 16'h0000;
    localparam int unsigned REG_WIDTH    = 16;

endpackage

// File: rtl/prco_fetch.sv
// Instruction fetch stage: owns the PC, strobes single-word reads into local memory
// and holds the returned word for the decoder under a valid/ready handshake.
module prco_fetch
    import prco_fetch_pkg::*;
#(
    parameter int unsigned               P_ADDR_WIDTH   = 16,
    parameter int unsigned               P_INSTR_WIDTH  = REG_WIDTH,
    parameter logic [P_ADDR_WIDTH-1:0]   P_RESET_VECTOR = RESET_VECTOR
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_run,
    input  logic                     i_port_busy,
    output logic                     q_ce_fetch,
    output logic [P_ADDR_WIDTH-1:0]  q_mem_addr,
    input  logic                     i_mem_valid,
    input  logic [P_INSTR_WIDTH-1:0] i_mem_douta,
    output logic [P_INSTR_WIDTH-1:0] q_instr,
    output logic [P_ADDR_WIDTH-1:0]  q_instr_pc,
    output logic                     q_instr_valid,
    input  logic                     i_dec_ready,
    input  logic                     i_branch_en,
    input  logic [P_ADDR_WIDTH-1:0]  i_branch_addr,
    output logic [P_ADDR_WIDTH-1:0]  q_pc,
    output logic                     q_busy
);

    localparam logic [P_ADDR_WIDTH-1:0] PC_ONE = {{(P_ADDR_WIDTH-1){1'b0}}, 1'b1};

    fetch_state_t                state_q, state_d;
    logic                        kill_q, kill_d;
    logic                        ce_d, busy_d, valid_d, issue_ok;
    logic [P_ADDR_WIDTH-1:0]     pc_d, addr_d, ipc_d;
    logic [P_INSTR_WIDTH-1:0]    instr_d;

    always_comb begin
        state_d  = state_q;
        kill_d   = kill_q;
        pc_d     = q_pc;
        ce_d     = 1'b0;
        addr_d   = q_mem_addr;
        instr_d  = q_instr;
        ipc_d    = q_instr_pc;
        valid_d  = q_instr_valid;
        issue_ok = i_run & ~i_port_busy & ~i_branch_en;

        case (state_q)
            FETCH_ISSUE: begin
                if (i_branch_en) begin
                    pc_d = i_branch_addr;
                end else if (issue_ok) begin
                    ce_d    = 1'b1;
                    addr_d  = q_pc;
                    state_d = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (i_branch_en) begin
                    pc_d = i_branch_addr;
                    if (i_mem_valid) begin
                        kill_d  = 1'b0;
                        state_d = FETCH_ISSUE;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (i_mem_valid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = FETCH_ISSUE;
                    end else begin
                        instr_d = i_mem_douta;
                        ipc_d   = q_pc;
                        pc_d    = q_pc + PC_ONE;
                        valid_d = 1'b1;
                        state_d = FETCH_HOLD;
                    end
                end
            end
            FETCH_HOLD: begin
                if (i_branch_en) begin
                    pc_d    = i_branch_addr;
                    valid_d = 1'b0;
                    state_d = FETCH_ISSUE;
                end else if (i_dec_ready && q_instr_valid) begin
                    valid_d = 1'b0;
                    // Accept and ISSUE are folded into one cycle to sustain one word per 3 cycles.
                    if (issue_ok) begin
                        ce_d    = 1'b1;
                        addr_d  = q_pc;
                        state_d = FETCH_WAIT;
                    end else begin
                        state_d = FETCH_ISSUE;
                    end
                end
            end
            default: state_d = FETCH_ISSUE;
        endcase

        busy_d = (state_d == FETCH_WAIT);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q       <= FETCH_ISSUE;
            kill_q        <= 1'b0;
            q_pc          <= P_RESET_VECTOR;
            q_ce_fetch    <= 1'b0;
            q_mem_addr    <= '0;
            q_instr       <= '0;
            q_instr_pc    <= '0;
            q_instr_valid <= 1'b0;
            q_busy        <= 1'b0;
        end else begin
            state_q       <= state_d;
            kill_q        <= kill_d;
            q_pc          <= pc_d;
            q_ce_fetch    <= ce_d;
            q_mem_addr    <= addr_d;
            q_instr       <= instr_d;
            q_instr_pc    <= ipc_d;
            q_instr_valid <= valid_d;
            q_busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_prco_fetch.sv
// Directed bench for prco_fetch with a fixed-latency (1 cycle) memory model.
module tb_prco_fetch;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_run, i_port_busy, i_dec_ready, i_branch_en;
    logic [15:0] i_branch_addr;
    logic        i_mem_valid;
    logic [15:0] i_mem_douta;
    logic        q_ce_fetch, q_instr_valid, q_busy;
    logic [15:0] q_mem_addr, q_instr, q_instr_pc, q_pc;

    logic        mdl_valid = 1'b0;
    logic [15:0] mdl_data  = '0;
    logic        alu_valid;
    logic [15:0] alu_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 i_clk = ~i_clk;

    prco_fetch #(
        .P_ADDR_WIDTH   (16),
        .P_INSTR_WIDTH  (16),
        .P_RESET_VECTOR (16'h0000)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_run         (i_run),
        .i_port_busy   (i_port_busy),
        .q_ce_fetch    (q_ce_fetch),
        .q_mem_addr    (q_mem_addr),
        .i_mem_valid   (i_mem_valid),
        .i_mem_douta   (i_mem_douta),
        .q_instr       (q_instr),
        .q_instr_pc    (q_instr_pc),
        .q_instr_valid (q_instr_valid),
        .i_dec_ready   (i_dec_ready),
        .i_branch_en   (i_branch_en),
        .i_branch_addr (i_branch_addr),
        .q_pc          (q_pc),
        .q_busy        (q_busy)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0000)      return 16'h20AB;
        else if (a == 16'h00AA) return 16'h00CA;
        else                    return a ^ 16'h1200;
    endfunction

    // Memory answers the cycle after each strobe.
    always @(posedge i_clk) begin
        mdl_valid <= q_ce_fetch;
        mdl_data  <= mem_word(q_mem_addr);
    end

    assign i_mem_valid = mdl_valid | alu_valid;
    assign i_mem_douta = alu_valid ? alu_data : mdl_data;

    task automatic step();
        @(negedge i_clk);
    endtask

    task automatic test_reset();
        step(); step();
        n_cmp++;
        if ({q_ce_fetch, q_mem_addr, q_instr, q_instr_pc, q_instr_valid, q_busy, q_pc} !== 67'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got ce=%b addr=%h instr=%h ipc=%h v=%b busy=%b pc=%h required all 0",
                     q_ce_fetch, q_mem_addr, q_instr, q_instr_pc, q_instr_valid, q_busy, q_pc);
        end
    endtask

    task automatic test_first_fetch();
        i_run   = 1'b1;
        i_reset = 1'b1;
        step();
        n_cmp++;
        if ({q_ce_fetch, q_mem_addr, q_busy} !== {1'b1, 16'h0000, 1'b1}) begin
            n_bad++;
            $display("FAIL first_strobe: got ce=%b addr=%h busy=%b required 1/0000/1", q_ce_fetch, q_mem_addr, q_busy);
        end
        step();
        n_cmp++;
        if ({q_ce_fetch, q_instr_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL first_wait: got ce=%b v=%b required 0/0", q_ce_fetch, q_instr_valid);
        end
        step();
        n_cmp++;
        if ({q_instr_valid, q_instr, q_instr_pc, q_pc, q_busy} !== {1'b1, 16'h20AB, 16'h0000, 16'h0001, 1'b0}) begin
            n_bad++;
            $display("FAIL first_capture: got v=%b instr=%h ipc=%h pc=%h busy=%b required 1/20AB/0000/0001/0",
                     q_instr_valid, q_instr, q_instr_pc, q_pc, q_busy);
        end
        step();
        n_cmp++;
        if ({q_instr_valid, q_instr, q_ce_fetch} !== {1'b1, 16'h20AB, 1'b0}) begin
            n_bad++;
            $display("FAIL hold_stable: got v=%b instr=%h ce=%b required 1/20AB/0", q_instr_valid, q_instr, q_ce_fetch);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] k16;
        i_dec_ready = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            k16 = 16'(k);
            step();
            n_cmp++;
            if ({q_ce_fetch, q_mem_addr, q_instr_valid} !== {1'b1, k16, 1'b0}) begin
                n_bad++;
                $display("FAIL b2b_strobe%0d: got ce=%b addr=%h v=%b required 1/%h/0", k, q_ce_fetch, q_mem_addr, q_instr_valid, k16);
            end
            step(); step();
            n_cmp++;
            if ({q_instr_valid, q_instr_pc, q_instr} !== {1'b1, k16, k16 ^ 16'h1200}) begin
                n_bad++;
                $display("FAIL b2b_word%0d: got v=%b ipc=%h instr=%h required 1/%h/%h", k, q_instr_valid, q_instr_pc, q_instr, k16, k16 ^ 16'h1200);
            end
        end
        i_run = 1'b0;
        step();
        n_cmp++;
        if ({q_ce_fetch, q_instr_valid, q_pc} !== {1'b0, 1'b0, 16'h0003}) begin
            n_bad++;
            $display("FAIL b2b_idle: got ce=%b v=%b pc=%h required 0/0/0003", q_ce_fetch, q_instr_valid, q_pc);
        end
        i_dec_ready = 1'b0;
    endtask

    task automatic test_branch_wait();
        i_run = 1'b1;
        step();
        n_cmp++;
        if ({q_ce_fetch, q_mem_addr} !== {1'b1, 16'h0003}) begin
            n_bad++;
            $display("FAIL bw_strobe: got ce=%b addr=%h required 1/0003", q_ce_fetch, q_mem_addr);
        end
        i_branch_en = 1'b1; i_branch_addr = 16'h00AA;
        step();
        i_branch_en = 1'b0;
        n_cmp++;
        if ({q_pc, i_mem_valid} !== {16'h00AA, 1'b1}) begin
            n_bad++;
            $display("FAIL bw_redirect: got pc=%h memv=%b required 00AA/1", q_pc, i_mem_valid);
        end
        step();
        n_cmp++;
        if ({q_instr_valid, q_ce_fetch, q_busy} !== 3'b000) begin
            n_bad++;
            $display("FAIL bw_discard: got v=%b ce=%b busy=%b required 0/0/0", q_instr_valid, q_ce_fetch, q_busy);
        end
        step();
        n_cmp++;
        if ({q_ce_fetch, q_mem_addr} !== {1'b1, 16'h00AA}) begin
            n_bad++;
            $display("FAIL bw_refetch: got ce=%b addr=%h required 1/00AA", q_ce_fetch, q_mem_addr);
        end
        step(); step();
        n_cmp++;
        if ({q_instr_valid, q_instr, q_instr_pc} !== {1'b1, 16'h00CA, 16'h00AA}) begin
            n_bad++;
            $display("FAIL bw_word: got v=%b instr=%h ipc=%h required 1/00CA/00AA", q_instr_valid, q_instr, q_instr_pc);
        end
    endtask

    task automatic test_branch_hold();
        i_dec_ready = 1'b1; i_branch_en = 1'b1; i_branch_addr = 16'h0010;
        step();
        i_dec_ready = 1'b0; i_branch_en = 1'b0;
        n_cmp++;
        if ({q_instr_valid, q_ce_fetch, q_pc} !== {1'b0, 1'b0, 16'h0010}) begin
            n_bad++;
            $display("FAIL bh_flush: got v=%b ce=%b pc=%h required 0/0/0010", q_instr_valid, q_ce_fetch, q_pc);
        end
        step();
        n_cmp++;
        if ({q_ce_fetch, q_mem_addr} !== {1'b1, 16'h0010}) begin
            n_bad++;
            $display("FAIL bh_refetch: got ce=%b addr=%h required 1/0010", q_ce_fetch, q_mem_addr);
        end
        step(); step();
        n_cmp++;
        if ({q_instr_valid, q_instr, q_instr_pc} !== {1'b1, 16'h1210, 16'h0010}) begin
            n_bad++;
            $display("FAIL bh_word: got v=%b instr=%h ipc=%h required 1/1210/0010", q_instr_valid, q_instr, q_instr_pc);
        end
        i_run = 1'b0; i_dec_ready = 1'b1;
        step();
        i_dec_ready = 1'b0;
    endtask

    task automatic test_port_busy();
        i_run = 1'b1; i_port_busy = 1'b1; alu_data = 16'hBEEF;
        for (int c = 0; c < 4; c++) begin
            alu_valid = (c % 2 == 0);
            step();
            n_cmp++;
            if ({q_ce_fetch, q_instr_valid, q_busy, q_pc} !== {3'b000, 16'h0011}) begin
                n_bad++;
                $display("FAIL pb_blocked%0d: got ce=%b v=%b busy=%b pc=%h required 0/0/0/0011", c, q_ce_fetch, q_instr_valid, q_busy, q_pc);
            end
        end
        alu_valid = 1'b0; i_port_busy = 1'b0;
        step();
        i_run = 1'b0;
        n_cmp++;
        if ({q_ce_fetch, q_mem_addr} !== {1'b1, 16'h0011}) begin
            n_bad++;
            $display("FAIL pb_issue: got ce=%b addr=%h required 1/0011", q_ce_fetch, q_mem_addr);
        end
        step(); step();
        n_cmp++;
        if ({q_instr_valid, q_instr, q_instr_pc} !== {1'b1, 16'h1211, 16'h0011}) begin
            n_bad++;
            $display("FAIL pb_word: got v=%b instr=%h ipc=%h required 1/1211/0011", q_instr_valid, q_instr, q_instr_pc);
        end
        i_dec_ready = 1'b1;
        step();
        i_dec_ready = 1'b0;
    endtask

    task automatic test_wrap_and_reset();
        i_run = 1'b1; i_branch_en = 1'b1; i_branch_addr = 16'hFFFF;
        step();
        i_branch_en = 1'b0;
        n_cmp++;
        if ({q_ce_fetch, q_pc} !== {1'b0, 16'hFFFF}) begin
            n_bad++;
            $display("FAIL wr_branch_issue: got ce=%b pc=%h required 0/FFFF", q_ce_fetch, q_pc);
        end
        step();
        n_cmp++;
        if ({q_ce_fetch, q_mem_addr} !== {1'b1, 16'hFFFF}) begin
            n_bad++;
            $display("FAIL wr_strobe: got ce=%b addr=%h required 1/FFFF", q_ce_fetch, q_mem_addr);
        end
        step(); step();
        n_cmp++;
        if ({q_instr_valid, q_instr, q_instr_pc, q_pc} !== {1'b1, 16'hEDFF, 16'hFFFF, 16'h0000}) begin
            n_bad++;
            $display("FAIL wr_wrap: got v=%b instr=%h ipc=%h pc=%h required 1/EDFF/FFFF/0000", q_instr_valid, q_instr, q_instr_pc, q_pc);
        end
        i_dec_ready = 1'b1; i_branch_en = 1'b1; i_branch_addr = 16'h0040;
        step();
        i_dec_ready = 1'b0; i_branch_en = 1'b0;
        step();
        n_cmp++;
        if ({q_ce_fetch, q_mem_addr, q_busy, q_pc} !== {1'b1, 16'h0040, 1'b1, 16'h0040}) begin
            n_bad++;
            $display("FAIL wr_pre_reset: got ce=%b addr=%h busy=%b pc=%h required 1/0040/1/0040", q_ce_fetch, q_mem_addr, q_busy, q_pc);
        end
        #2 i_reset = 1'b0;
        #1;
        n_cmp++;
        if ({q_ce_fetch, q_mem_addr, q_instr, q_instr_pc, q_instr_valid, q_busy, q_pc} !== 67'd0) begin
            n_bad++;
            $display("FAIL async_reset: got ce=%b addr=%h instr=%h ipc=%h v=%b busy=%b pc=%h required all 0",
                     q_ce_fetch, q_mem_addr, q_instr, q_instr_pc, q_instr_valid, q_busy, q_pc);
        end
        i_run = 1'b0;
        step();
        i_reset = 1'b1; alu_valid = 1'b1; alu_data = 16'h1234;
        step();
        alu_valid = 1'b0;
        n_cmp++;
        if ({q_instr_valid, q_instr, q_busy, q_pc} !== {1'b0, 16'h0000, 1'b0, 16'h0000}) begin
            n_bad++;
            $display("FAIL post_reset_ignore: got v=%b instr=%h busy=%b pc=%h required 0/0000/0/0000", q_instr_valid, q_instr, q_busy, q_pc);
        end
    endtask

    initial begin
        i_reset = 1'b0; i_run = 1'b0; i_port_busy = 1'b0; i_dec_ready = 1'b0;
        i_branch_en = 1'b0; i_branch_addr = '0; alu_valid = 1'b0; alu_data = '0;
        test_reset();
        test_first_fetch();
        test_back_to_back();
        test_branch_wait();
        test_branch_hold();
        test_port_busy();
        test_wrap_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
